alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the operand and result width in bits.
REQ-002 The block SHALL have parameter RES_DEPTH, default 2, meaning the number of result buffer entries (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: command present.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid is also high.
REQ-007 The block SHALL have ports cmd_a and cmd_b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port cmd_cin, input, 1 bit: carry-in.
REQ-009 The block SHALL have port cmd_sel, input, 2 bits: the operation select; bit 1 drives s1 and bit 0 drives s0.
REQ-010 The block SHALL have ports alu_a and alu_b, output, WIDTH bits each, and alu_cin, alu_s1 and alu_s0, output, 1 bit each: drive to the external combinational ALU.
REQ-011 The block SHALL have ports alu_f, input, WIDTH bits, and alu_cout, input, 1 bit: the ALU result return.
REQ-012 The block SHALL have ports res_valid, output, 1 bit, and res_ready, input, 1 bit: the result handshake.
REQ-013 The block SHALL have ports res_f, output, WIDTH bits, and res_cout, output, 1 bit: the buffered result.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE or the buffer is non-empty.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE and CAPTURE.
- IDLE -> ISSUE on a command handshake.
- ISSUE -> CAPTURE unconditionally.
- CAPTURE -> IDLE unconditionally.
REQ-016 On a command handshake, the block SHALL register cmd_a, cmd_b, cmd_cin and cmd_sel; the alu_* outputs SHALL present the registered values from the next cycle and hold them stable through ISSUE and CAPTURE.
REQ-017 In CAPTURE, the block SHALL write alu_f and alu_cout into the result buffer, giving the ALU one full cycle (ISSUE) to settle.
REQ-018 A command accepted in cycle N SHALL produce res_valid high in cycle N+3, provided the buffer was empty.
REQ-019 cmd_ready SHALL be high only in IDLE, and only when buffer occupancy is below RES_DEPTH; this guarantees no write into a full buffer.
REQ-020 The result buffer SHALL be FIFO-ordered, with res_f and res_cout taken from the head entry; res_valid SHALL equal "not empty".
REQ-021 A pop SHALL occur on res_valid and res_ready; a simultaneous push and pop SHALL keep occupancy unchanged and preserve order.
REQ-022 The read and write pointers SHALL wrap modulo RES_DEPTH.
REQ-023 res_f, res_cout and res_valid SHALL hold stable while res_valid is high and res_ready is low.
REQ-024 When the buffer is empty, res_f and res_cout SHALL be 0.

Reset
REQ-025 While rst_n is low at a clock edge, the block SHALL set FSM=IDLE, occupancy=0 and pointers=0.
REQ-026 While rst_n is low at a clock edge, the block SHALL clear all alu_* outputs, res_valid, res_f, res_cout and busy to 0, and hold cmd_ready at 0.
REQ-027 Reset asserted mid-operation (ISSUE or CAPTURE) SHALL discard the in-flight command, which SHALL NOT be written to the buffer.
REQ-028 cmd_ready SHALL rise no earlier than the first clock edge after rst_n returns high.

Configuration
REQ-029 With macro ALU_SEQ_CTRL_ACC_EN defined, the block SHALL add an input port cmd_acc (1 bit).
REQ-030 With ALU_SEQ_CTRL_ACC_EN defined and cmd_acc high on a handshake, the block SHALL use the last captured alu_f (an internal accumulator register, reset to 0) in place of cmd_a.
REQ-031 With ALU_SEQ_CTRL_ACC_EN defined, the accumulator SHALL update in every CAPTURE cycle.
REQ-032 Without ALU_SEQ_CTRL_ACC_EN, the block SHALL have no cmd_acc port and no accumulator, and cmd_a SHALL always be used.

Structure
REQ-033 Package alu_seq_pkg SHALL hold the FSM state typedef (IDLE, ISSUE, CAPTURE) and the cmd_sel encoding constants SEL_OP0 through SEL_OP3 (2'b00 through 2'b11).
REQ-034 The result buffer SHALL be a single sub-module, alu_res_fifo, parameterised by WIDTH+1 bits and RES_DEPTH.

Verification
REQ-035 The bench SHALL cover a single op: a=4'h3, b=4'h5, cin=0, sel=2'b00, with a model ALU of add; the required response is res_valid in cycle N+3 with res_f=4'h8 and res_cout=0.
REQ-036 The bench SHALL cover overflow: a=4'hF, b=4'h1, cin=1, add; the required response is res_f=4'h1 and res_cout=1.
REQ-037 The bench SHALL cover backpressure: res_ready=0 with three commands offered; two results are buffered, cmd_ready stays 0 after the second CAPTURE, and res_f stays stable.
REQ-038 The bench SHALL cover simultaneous push and pop: with res_ready=1 and back-to-back commands, results come out in order and occupancy never exceeds 1.
REQ-039 The bench SHALL cover reset mid-operation: rst_n=0 during ISSUE; the required response is all outputs 0, no result emitted, and cmd_ready=1 one cycle after release.
REQ-040 The bench SHALL cover accumulate, with ALU_SEQ_CTRL_ACC_EN defined: add a=2, b=3, then cmd_acc=1 with b=4; the required responses are res_f=5 then res_f=9.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared FSM state type and operation select encodings for alu_seq_ctrl
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_OP0 = 2'b00;
    localparam logic [1:0] SEL_OP1 = 2'b01;
    localparam logic [1:0] SEL_OP2 = 2'b10;
    localparam logic [1:0] SEL_OP3 = 2'b11;

endpackage

// File: rtl/alu_res_fifo.sv
// rtl/alu_res_fifo.sv - power-of-two depth result FIFO, head presented combinationally, zero when empty
module alu_res_fifo #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_tvalid,
    output logic              in_tready,
    input  logic [DATA_W-1:0] in_tdata,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic [DATA_W-1:0] out_tdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push;
    logic              pop;

    assign in_tready  = (count_q != CW'(DEPTH));
    assign out_tvalid = (count_q != '0);
    assign out_tdata  = out_tvalid ? mem_q[rptr_q] : '0;
    assign push       = in_tvalid && in_tready;
    assign pop        = out_tvalid && out_tready;

    // Pointer, occupancy and storage update; pointers wrap naturally at the power-of-two depth
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[wptr_q] = in_tdata;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequences commands through an external ALU into a result FIFO; ALU_SEQ_CTRL_ACC_EN adds accumulate
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int RES_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    input  logic [1:0]       cmd_sel,
`ifdef ALU_SEQ_CTRL_ACC_EN
    input  logic             cmd_acc,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic             alu_s1,
    output logic             alu_s0,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_f,
    output logic             res_cout,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic [1:0]       sel_q, sel_d;
    logic             init_q, init_d;
    logic             fifo_in_tready;
    logic             accept;
    logic             push;
`ifdef ALU_SEQ_CTRL_ACC_EN
    logic [WIDTH-1:0] acc_q, acc_d;
`endif

    assign accept    = cmd_valid && cmd_ready;
    assign push      = (state_q == CAPTURE);
    assign cmd_ready = init_q && (state_q == IDLE) && fifo_in_tready;
    assign busy      = (state_q != IDLE) || res_valid;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_cin   = cin_q;
    assign alu_s1    = sel_q[1];
    assign alu_s0    = sel_q[0];

    // Next state and operand latching; operands stay frozen from acceptance until the next command
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sel_d   = sel_q;
        init_d  = 1'b1;
`ifdef ALU_SEQ_CTRL_ACC_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
`ifdef ALU_SEQ_CTRL_ACC_EN
                    a_d     = cmd_acc ? acc_q : cmd_a;
`else
                    a_d     = cmd_a;
`endif
                    b_d     = cmd_b;
                    cin_d   = cmd_cin;
                    sel_d   = cmd_sel;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = IDLE;
`ifdef ALU_SEQ_CTRL_ACC_EN
                acc_d   = alu_f;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; init_q keeps cmd_ready low until one edge after reset release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sel_q   <= '0;
            init_q  <= 1'b0;
`ifdef ALU_SEQ_CTRL_ACC_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sel_q   <= sel_d;
            init_q  <= init_d;
`ifdef ALU_SEQ_CTRL_ACC_EN
            acc_q   <= acc_d;
`endif
        end
    end

    alu_res_fifo #(
        .DATA_W (WIDTH + 1),
        .DEPTH  (RES_DEPTH)
    ) u_res_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_tvalid  (push),
        .in_tready  (fifo_in_tready),
        .in_tdata   ({alu_cout, alu_f}),
        .out_tvalid (res_valid),
        .out_tready (res_ready),
        .out_tdata  ({res_cout, res_f})
    );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl with a behavioural external ALU
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_cin;
    logic [1:0]   cmd_sel;
    logic         cmd_acc;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_cin;
    logic         alu_s1;
    logic         alu_s0;
    logic [W-1:0] alu_f;
    logic         alu_cout;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_f;
    logic         res_cout;
    logic         busy;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W:0]   exp_q[$];
    logic [W:0]   mon_e;
    logic [W-1:0] m_acc;
    logic         chk_occ = 1'b0;
    logic [W-1:0] held_f;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(W), .RES_DEPTH(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_cin   (cmd_cin),
        .cmd_sel   (cmd_sel),
`ifdef ALU_SEQ_CTRL_ACC_EN
        .cmd_acc   (cmd_acc),
`endif
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_s1    (alu_s1),
        .alu_s0    (alu_s0),
        .alu_f     (alu_f),
        .alu_cout  (alu_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_f     (res_f),
        .res_cout  (res_cout),
        .busy      (busy)
    );

    function automatic logic [W:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic [1:0] sel);
        logic [W:0] r;
        case (sel)
            SEL_OP0: r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            SEL_OP1: r = {1'b0, a & b};
            SEL_OP2: r = {1'b0, a | b};
            default: r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    // External combinational ALU
    always_comb begin
        {alu_cout, alu_f} = alu_model(alu_a, alu_b, alu_cin, {alu_s1, alu_s0});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [1:0] sel, input logic acc);
        int         t;
        logic [W-1:0] opa;
        logic [W:0] e;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        cmd_sel   = sel;
        cmd_acc   = acc;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 100) begin
            tick();
            t++;
        end
        chk("send_accept", 32'(t < 100), 1);
`ifdef ALU_SEQ_CTRL_ACC_EN
        opa = acc ? m_acc : a;
`else
        opa = a;
`endif
        e = alu_model(opa, b, cin, sel);
        exp_q.push_back(e);
        m_acc = e[W-1:0];
        tick();
        cmd_valid = 1'b0;
        cmd_acc   = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Result monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("res_f", res_f, mon_e[W-1:0]);
                chk("res_cout", res_cout, mon_e[W]);
            end
        end
        if (chk_occ) begin
            chk("occ_le1", 32'(u_dut.u_res_fifo.count_q <= 1), 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; cmd_sel = '0; cmd_acc = 1'b0;
        m_acc = '0;
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res", {res_cout, res_f}, 0);
        chk("rst_alu_ab", {alu_a, alu_b}, 0);
        chk("rst_alu_ctl", {alu_cin, alu_s1, alu_s0}, 0);
        rst_n = 1'b1;
        chk("rel_cmd_ready_low", cmd_ready, 0);
        tick();
        chk("rel_cmd_ready_high", cmd_ready, 1);

        // single add, latency N+3
        send(4'h3, 4'h5, 1'b0, SEL_OP0, 1'b0);
        chk("lat_n1_valid", res_valid, 0);
        chk("lat_n1_alu", {alu_a, alu_b}, 8'h35);
        chk("lat_n1_busy", busy, 1);
        tick();
        chk("lat_n2_valid", res_valid, 0);
        chk("lat_n2_alu", {alu_a, alu_b}, 8'h35);
        tick();
        chk("lat_n3_valid", res_valid, 1);
        chk("lat_n3_f", res_f, 4'h8);
        chk("lat_n3_cout", res_cout, 0);
        res_ready = 1'b1;
        drain();
        chk("empty_res_zero", {res_cout, res_f}, 0);

        // back-to-back with res_ready high: overflow and other ops, occupancy bounded
        chk_occ = 1'b1;
        send(4'hF, 4'h1, 1'b1, SEL_OP0, 1'b0);
        send(4'hC, 4'hA, 1'b0, SEL_OP1, 1'b0);
        send(4'hC, 4'hA, 1'b0, SEL_OP2, 1'b0);
        send(4'hC, 4'hA, 1'b1, SEL_OP3, 1'b0);
        send(4'h9, 4'h9, 1'b0, SEL_OP0, 1'b0);
        drain();
        chk_occ = 1'b0;

        // backpressure: two buffered, third held off
        res_ready = 1'b0;
        send(4'h1, 4'h1, 1'b0, SEL_OP0, 1'b0);
        send(4'h2, 4'h2, 1'b0, SEL_OP0, 1'b0);
        tick();
        tick();
        chk("bp_full_ready", cmd_ready, 0);
        chk("bp_valid", res_valid, 1);
        chk("bp_head", res_f, 4'h2);
        held_f = res_f;
        cmd_a = 4'h7; cmd_b = 4'h1; cmd_cin = 1'b0; cmd_sel = SEL_OP0; cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_ready", cmd_ready, 0);
            chk("bp_hold_valid", res_valid, 1);
            chk("bp_hold_f", res_f, held_f);
        end
        chk("bp_occ", u_dut.u_res_fifo.count_q, 2);
        res_ready = 1'b1;
        send(4'h7, 4'h1, 1'b0, SEL_OP0, 1'b0);
        drain();

        // reset during ISSUE discards the command
        send(4'h6, 4'h6, 1'b0, SEL_OP0, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        m_acc = '0;
        tick();
        chk("mid_rst_alu", {alu_a, alu_b, alu_cin, alu_s1, alu_s0}, 0);
        chk("mid_rst_res", {res_valid, res_cout, res_f}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        tick();
        rst_n = 1'b1;
        chk("mid_rel_ready_low", cmd_ready, 0);
        tick();
        chk("mid_rel_ready_high", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_result", res_valid, 0);
        end

`ifdef ALU_SEQ_CTRL_ACC_EN
        send(4'h2, 4'h3, 1'b0, SEL_OP0, 1'b0);
        send(4'h0, 4'h4, 1'b0, SEL_OP0, 1'b1);
        drain();
`endif

        repeat (3) tick();
        chk("final_sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
